sweep_ctrl_multi: RTL and testbench

Avalon-MM slave that sweeps a contiguous block of read addresses across NUM_CH parallel test channels and issues write-backs. Write address and write enable trail each read address by a fixed pipeline latency. Single-clock successor of the dual-clock adder test controller, with parametrised address width, channel count, datapath latency, loop mode and abort. It sits between the HPS Avalon bridge and the channel input/output RAMs of a test harness.

---
 rtl/sweep_ctrl_multi.sv | 218 +++++++++++++++++++++
 tb/tb_sweep_ctrl_multi.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_ctrl_multi.sv
// -----------------------------------------------------------------------------
// sweep_ctrl_multi
//
// Avalon-MM slave that sweeps a contiguous block of read addresses, shared by
// NUM_CH test channels, and issues per-channel write-backs PIPE_LAT cycles
// after each read address. Supports one-shot and loop sweeps and abort.
//
// Optional build macro: SWEEP_CYCLE_COUNTER_EN
//   defined   -> CYCLES register is a saturating 32-bit busy-cycle counter
//   undefined -> CYCLES reads 0
//
// Ports
//   avalon_clock  sole clock (Avalon fabric and RAM ports)
//   resetn        asynchronous active-low reset
//   address       register select (0 CTRL, 1 START, 2 END, 3 MASK, 4 ID,
//                 5 CYCLES, 6 PASSES, 7 reads 0)
//   write         register write strobe, writedata its data
//   read          register read strobe, readdata registered the cycle after
//   r_addr        read address shared by all channels
//   w_addr        write-back address shared by all channels
//   we            per-channel result-RAM write enables
//   we_read       read-RAM write enables, tied low
//   busy          high while sweeping or draining
//
// State table
//   state | meaning
//   IDLE  | reset state, waiting for go
//   RUN   | issuing one read address per cycle
//   DRAIN | pipe flushing, PIPE_LAT cycles of zero valid bits
//   DONE  | sweep finished, done sticky until next go
// -----------------------------------------------------------------------------
module sweep_ctrl_multi #(
   parameter logic [31:0] ID       = 32'd1,
   parameter int          ADDR_W   = 11,
   parameter int          NUM_CH   = 2,
   parameter int          PIPE_LAT = 2
) (
   input  logic              avalon_clock,
   input  logic              resetn,
   input  logic [2:0]        address,
   input  logic              write,
   input  logic [31:0]       writedata,
   input  logic              read,
   output logic [31:0]       readdata,
   output logic [ADDR_W-1:0] r_addr,
   output logic [ADDR_W-1:0] w_addr,
   output logic [NUM_CH-1:0] we,
   output logic [NUM_CH-1:0] we_read,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [DW-1:0]   DRAIN_INIT = DW'(PIPE_LAT - 1);
   localparam logic [ADDR_W:0] END_ONE    = {{ADDR_W{1'b0}}, 1'b1};

   state_t              state;
   logic [ADDR_W-1:0]   start_reg;
   logic [ADDR_W:0]     end_reg;
   logic [NUM_CH-1:0]   mask_reg;
   logic [NUM_CH-1:0]   mask_run;
   logic                loop_run;
   logic                done;
   logic [15:0]         passes;
   logic [31:0]         cycles;
   logic [DW-1:0]       drain_cnt;

   logic [ADDR_W-1:0]   addr_pipe [PIPE_LAT];
   logic [NUM_CH-1:0]   we_pipe   [PIPE_LAT];

   logic                ctrl_wr;
   logic                go_req;
   logic                abort_req;
   logic                last_addr;
   logic                zero_len;
   logic [31:0]         rd_mux;
   logic                unused_wdata;

   assign ctrl_wr   = write && (address == 3'd0);
   assign go_req    = ctrl_wr && writedata[0];
   assign abort_req = ctrl_wr && !writedata[0];
   // END is one bit wider than r_addr so END = 2^ADDR_W ends on the top address
   assign last_addr = ({1'b0, r_addr} == (end_reg - END_ONE));
   assign zero_len  = !({1'b0, start_reg} < end_reg);
   assign we_read   = '0;
   assign unused_wdata = ^writedata;

   // Sweep sequencer
   always_ff @(posedge avalon_clock or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         r_addr    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         loop_run  <= 1'b0;
         mask_run  <= '0;
         passes    <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (go_req) begin
                  r_addr   <= start_reg;
                  passes   <= '0;
                  done     <= 1'b0;
                  loop_run <= writedata[1];
                  mask_run <= mask_reg;
                  busy     <= 1'b1;
                  if (zero_len) begin
                     state     <= DRAIN;
                     drain_cnt <= DRAIN_INIT;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (last_addr) begin
                  if (passes != 16'hFFFF)
                     passes <= passes + 16'd1;
                  r_addr <= loop_run ? start_reg : r_addr + ADDR_W'(1);
               end else begin
                  r_addr <= r_addr + ADDR_W'(1);
               end
               // abort still lets the address issued this cycle reach its write-back
               if (abort_req || (last_addr && !loop_run)) begin
                  state     <= DRAIN;
                  drain_cnt <= DRAIN_INIT;
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - DW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Write-back delay line; per-channel enables are formed at issue time so
   // the output stage is a plain register.
   always_ff @(posedge avalon_clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < PIPE_LAT; i++) begin
            addr_pipe[i] <= '0;
            we_pipe[i]   <= '0;
         end
      end else begin
         addr_pipe[0] <= r_addr;
         we_pipe[0]   <= (state == RUN) ? mask_run : '0;
         for (int i = 1; i < PIPE_LAT; i++) begin
            addr_pipe[i] <= addr_pipe[i-1];
            we_pipe[i]   <= we_pipe[i-1];
         end
      end
   end

   assign w_addr = addr_pipe[PIPE_LAT-1];
   assign we     = we_pipe[PIPE_LAT-1];

   // Configuration registers, frozen while a sweep is in progress
   always_ff @(posedge avalon_clock or negedge resetn) begin
      if (!resetn) begin
         start_reg <= '0;
         end_reg   <= '0;
         mask_reg  <= '1;
      end else if (write && !busy) begin
         case (address)
            3'd1:    start_reg <= writedata[ADDR_W-1:0];
            3'd2:    end_reg   <= writedata[ADDR_W:0];
            3'd3:    mask_reg  <= writedata[NUM_CH-1:0];
            default: ;
         endcase
      end
   end

`ifdef SWEEP_CYCLE_COUNTER_EN
   always_ff @(posedge avalon_clock or negedge resetn) begin
      if (!resetn)
         cycles <= '0;
      else if (((state == IDLE) || (state == DONE)) && go_req)
         cycles <= '0;
      else if (busy && (cycles != 32'hFFFF_FFFF))
         cycles <= cycles + 32'd1;
   end
`else
   assign cycles = '0;
`endif

   always_comb begin
      rd_mux = '0;
      case (address)
         3'd0:    rd_mux = {29'b0, done, loop_run, busy};
         3'd1:    rd_mux[ADDR_W-1:0] = start_reg;
         3'd2:    rd_mux[ADDR_W:0]   = end_reg;
         3'd3:    rd_mux[NUM_CH-1:0] = mask_reg;
         3'd4:    rd_mux = ID;
         3'd5:    rd_mux = cycles;
         3'd6:    rd_mux[15:0] = passes;
         default: rd_mux = '0;
      endcase
   end

   // Registered read port; a same-cycle write is not visible until next read
   always_ff @(posedge avalon_clock or negedge resetn) begin
      if (!resetn)
         readdata <= '0;
      else if (read)
         readdata <= rd_mux;
   end

endmodule

// File: tb/tb_sweep_ctrl_multi.sv
`timescale 1ns/1ps
module tb_sweep_ctrl_multi;
   localparam int          AW  = 11;
   localparam int          NCH = 2;
   localparam int          PL  = 2;
   localparam logic [31:0] IDV = 32'h5EED_0042;

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic [2:0]      address;
   logic            write;
   logic [31:0]     writedata;
   logic            read;
   logic [31:0]     readdata;
   logic [AW-1:0]   r_addr;
   logic [AW-1:0]   w_addr;
   logic [NCH-1:0]  we;
   logic [NCH-1:0]  we_read;
   logic            busy;

   sweep_ctrl_multi #(.ID(IDV), .ADDR_W(AW), .NUM_CH(NCH), .PIPE_LAT(PL)) dut (
      .avalon_clock(clk), .resetn(resetn), .address(address), .write(write),
      .writedata(writedata), .read(read), .readdata(readdata), .r_addr(r_addr),
      .w_addr(w_addr), .we(we), .we_read(we_read), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int             cyc;
      logic [AW-1:0]  addr;
      logic [NCH-1:0] we;
   } wr_t;

   wr_t          wr_q[$];
   logic [31:0]  rd_q[$];
   string        rd_name_q[$];
   int           n_checks = 0;
   int           n_pass = 0;

   logic [AW-1:0]  m_start;
   logic [AW:0]    m_end;
   logic [NCH-1:0] m_mask;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endfunction

   // Monitor: readdata the cycle after a read, and every write-back pulse
   initial begin
      forever begin
         @(negedge clk);
         if (rd_q.size() > 0)
            chk(rd_name_q.pop_front(), 64'(readdata), 64'(rd_q.pop_front()));
         if (we !== '0) begin
            if (wr_q.size() == 0) begin
               chk("spurious_we", 64'(we), 64'(0));
            end else begin
               wr_t x;
               x = wr_q.pop_front();
               chk("we_cycle", 64'(cyc), 64'(x.cyc));
               chk("w_addr", 64'(w_addr), 64'(x.addr));
               chk("we", 64'(we), 64'(x.we));
            end
         end
      end
   end

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; writedata = d; write = 1'b1;
      @(posedge clk); #1;
      write = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string name);
      @(negedge clk);
      address = a; read = 1'b1;
      @(posedge clk); #1;
      read = 1'b0;
      rd_q.push_back(exp);
      rd_name_q.push_back(name);
   endtask

   function automatic logic [31:0] exp_cycles(input int n);
`ifdef SWEEP_CYCLE_COUNTER_EN
      return 32'(n + PL);
`else
      return (n >= 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   task automatic read_all_regs(input logic [31:0] ctrl_exp, input logic [31:0] pass_exp,
                                input logic [31:0] cyc_exp);
      bus_read(3'd0, ctrl_exp, "rb_ctrl");
      bus_read(3'd1, 32'(m_start), "rb_start");
      bus_read(3'd2, 32'(m_end), "rb_end");
      bus_read(3'd3, 32'(m_mask), "rb_mask");
      bus_read(3'd4, IDV, "rb_id");
      bus_read(3'd5, cyc_exp, "rb_cycles");
      bus_read(3'd6, pass_exp, "rb_passes");
      bus_read(3'd7, 32'd0, "rb_addr7");
   endtask

   // j: issued-address count at which go=0 is written (0 = never)
   task automatic run_sweep(input logic [31:0] s_raw, input logic [31:0] e_raw,
                            input logic [31:0] m_raw, input logic loop, input int j,
                            input bit pokes);
      int s, e, len, n, g, t, passes;
      logic [NCH-1:0] m;
      wr_t x;
      bus_write(3'd1, s_raw); m_start = s_raw[AW-1:0];
      bus_write(3'd2, e_raw); m_end   = e_raw[AW:0];
      bus_write(3'd3, m_raw); m_mask  = m_raw[NCH-1:0];
      s = int'(m_start);
      e = int'(m_end);
      m = m_mask;
      len = (s < e) ? e - s : 0;
      if (len == 0)        n = 0;
      else if (loop)       n = j;
      else if (j > 0 && j <= len) n = j;
      else                 n = len;
      passes = (len > 0) ? n / len : 0;

      bus_write(3'd0, {30'b0, loop, 1'b1});
      g = cyc;
      for (int k = 0; k < n; k++) begin
         if (m != '0) begin
            x.cyc  = g + k + PL;
            x.addr = AW'(s + k % len);
            x.we   = m;
            wr_q.push_back(x);
         end
      end
      if (len > 0) chk("r_addr_first", 64'(r_addr), 64'(s));

      if (pokes) begin
         bus_write(3'd1, ~s_raw);
         bus_write(3'd2, 32'd5);
         bus_write(3'd3, ~m_raw);
         bus_write(3'd0, 32'h3);
         bus_read(3'd1, 32'(m_start), "start_busy");
         bus_read(3'd0, {29'b0, 1'b0, loop, 1'b1}, "ctrl_busy");
      end else if (j > 0 && len > 0 && (loop || j <= len)) begin
         repeat (j - 1) @(posedge clk);
         bus_write(3'd0, 32'd0);
      end

      t = 0;
      while (busy !== 1'b0 && t < 5000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 5000) chk("done_timeout", 64'(busy), 64'(0));
      chk("done_cycle", 64'(cyc), 64'(g + n + PL));
      bus_read(3'd0, {29'b0, 1'b1, loop, 1'b0}, "ctrl_done");
      bus_read(3'd6, 32'(passes), "passes");
      bus_read(3'd5, exp_cycles(n), "cycles");
      if (pokes) begin
         bus_read(3'd1, 32'(m_start), "start_kept");
         bus_read(3'd2, 32'(m_end), "end_kept");
         bus_read(3'd3, 32'(m_mask), "mask_kept");
      end
   endtask

   initial begin
      int s, e, len, j, r;
      logic lp;
      wr_t x;
      address = '0; write = 1'b0; writedata = '0; read = 1'b0;
      m_start = '0; m_end = '0; m_mask = '1;

      repeat (2) @(posedge clk); #1;
      chk("rst_we", 64'(we), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_r_addr", 64'(r_addr), 64'(0));
      chk("rst_w_addr", 64'(w_addr), 64'(0));
      chk("rst_readdata", 64'(readdata), 64'(0));
      @(negedge clk) resetn = 1'b1;
      read_all_regs(32'd0, 32'd0, 32'd0);

      run_sweep(32'd4, 32'd8, 32'd3, 1'b0, 0, 1'b0);
      run_sweep(32'd5, 32'd5, 32'd3, 1'b0, 0, 1'b0);
      run_sweep(32'd0, 32'd3, 32'd1, 1'b1, 10, 1'b0);
      run_sweep(32'd2040, 32'd2048, 32'd3, 1'b0, 0, 1'b0);
      run_sweep(32'd10, 32'd40, 32'd2, 1'b0, 0, 1'b1);

      // simultaneous read and write returns the old value
      @(negedge clk);
      address = 3'd1; writedata = 32'd77; write = 1'b1; read = 1'b1;
      @(posedge clk); #1;
      write = 1'b0; read = 1'b0;
      rd_q.push_back(32'(m_start)); rd_name_q.push_back("rw_same_reg");
      m_start = 11'd77;
      bus_read(3'd1, 32'd77, "rw_after");

      for (int it = 0; it < 16; it++) begin
         r = int'($urandom_range(0, 3));
         lp = 1'b0;
         j = 0;
         case (r)
            0: begin
               s = int'($urandom_range(0, 2047));
               e = s + int'($urandom_range(0, 12));
               if (e > 2048) e = 2048;
            end
            1: begin
               e = 2048;
               s = e - int'($urandom_range(1, 10));
            end
            2: begin
               s = int'($urandom_range(10, 2000));
               e = s - int'($urandom_range(0, 9));
            end
            default: begin
               len = int'($urandom_range(1, 5));
               s = int'($urandom_range(0, 2040));
               e = s + len;
               lp = 1'b1;
               j = int'($urandom_range(1, 3 * len + 2));
            end
         endcase
         if (!lp && s < e && $urandom_range(0, 2) == 0)
            j = int'($urandom_range(1, e - s));
         run_sweep(($urandom & 32'hFFFF_F800) | 32'(s),
                   ($urandom & 32'hFFFF_F000) | 32'(e),
                   $urandom, lp, j, 1'b0);
      end

      repeat (PL + 2) @(posedge clk);
      chk("wr_q_drained", 64'(wr_q.size()), 64'(0));

      // reset in the middle of a sweep
      bus_write(3'd1, 32'd100); m_start = 11'd100;
      bus_write(3'd2, 32'd300); m_end = 12'd300;
      bus_write(3'd3, 32'd3);   m_mask = 2'b11;
      bus_write(3'd0, 32'd1);
      for (int k = 0; k < 200; k++) begin
         x.cyc = cyc + k + PL; x.addr = AW'(100 + k); x.we = 2'b11;
         wr_q.push_back(x);
      end
      repeat (10) @(posedge clk);
      @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("async_we", 64'(we), 64'(0));
      chk("async_busy", 64'(busy), 64'(0));
      chk("async_w_addr", 64'(w_addr), 64'(0));
      chk("async_r_addr", 64'(r_addr), 64'(0));
      wr_q.delete();
      m_start = '0; m_end = '0; m_mask = '1;
      @(negedge clk) resetn = 1'b1;
      read_all_regs(32'd0, 32'd0, 32'd0);
      repeat (3) @(posedge clk);
      chk("we_read", 64'(we_read), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
